// File: rtl/bus_rr_matrix.sv
// Shared bus: round-robin owner arbitration with hold, address-decoded slave select,
// owner muxing and one-cycle registered read return. Optional macro: BUS_TIMEOUT_EN.
module bus_rr_matrix #(
    parameter int N_MASTER = 4,
    parameter int N_SLAVE  = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTER-1:0]          m_req,
    input  logic [N_MASTER-1:0]          m_wr,
    input  logic [N_MASTER*ADDR_W-1:0]   m_address,
    input  logic [N_MASTER*DATA_W-1:0]   m_dout,
    input  logic [N_SLAVE*DATA_W-1:0]    s_dout,
    output logic [N_MASTER-1:0]          m_grant,
    output logic [DATA_W-1:0]            m_din,
    output logic [N_SLAVE-1:0]           s_sel,
    output logic [ADDR_W-1:0]            s_address,
    output logic                         s_wr,
    output logic [DATA_W-1:0]            s_din
);
    localparam int SEL_W = $clog2(N_SLAVE);
    localparam int OW    = $clog2(N_MASTER);

    if (N_MASTER < 2 || N_SLAVE < 2 || ADDR_W <= SEL_W || MAX_HOLD < 1) begin : g_bad_param
        $error("bus_rr_matrix: illegal parameter combination");
    end

    logic [OW-1:0]       owner, owner_nxt;
    logic [N_MASTER-1:0] grant_q;
    logic [N_SLAVE-1:0]  sel_q;
    logic [SEL_W-1:0]    idx;
    logic                owner_req;
    logic                force_move;

    assign owner_req = m_req[owner];
    assign m_grant   = grant_q;

`ifdef BUS_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;
    logic              contend;

    assign contend = |(m_req & ~grant_q);
    // Fire on the last allowed cycle so the owner holds exactly MAX_HOLD cycles under contention.
    assign force_move = contend && (int'(hold_cnt) == MAX_HOLD - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold_cnt <= '0;
        else if (owner_nxt != owner || !contend)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + 1'b1;
    end
`else
    assign force_move = 1'b0;
`endif

    // Round-robin scan starting just after the current owner; park if nobody asks.
    always_comb begin
        int cand;
        logic found;
        owner_nxt = owner;
        found     = 1'b0;
        cand      = 0;
        if (!owner_req || force_move) begin
            for (int k = 1; k < N_MASTER; k++) begin
                cand = (int'(owner) + k) % N_MASTER;
                if (!found && m_req[cand]) begin
                    found     = 1'b1;
                    owner_nxt = OW'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner   <= '0;
            grant_q <= N_MASTER'(1);
            sel_q   <= '0;
        end else begin
            owner   <= owner_nxt;
            grant_q <= N_MASTER'(1) << owner_nxt;
            sel_q   <= s_sel;
        end
    end

    assign s_address = m_address[int'(owner)*ADDR_W +: ADDR_W];
    assign s_din     = m_dout[int'(owner)*DATA_W +: DATA_W];
    assign s_wr      = m_wr[owner] & owner_req;
    assign idx       = s_address[ADDR_W-1 -: SEL_W];

    // Top address bits pick the slave; indices past N_SLAVE decode to nothing.
    always_comb begin
        s_sel = '0;
        if (owner_req && int'(idx) < N_SLAVE)
            s_sel[idx] = 1'b1;
    end

    always_comb begin
        m_din = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            if (sel_q[k])
                m_din = m_din | s_dout[k*DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_bus_rr_matrix.sv
// Bench for bus_rr_matrix: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural bus model.
module tb_bus_rr_matrix;
    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MH = 16;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NM-1:0]     req = '0;
    logic [NM-1:0]     wr = '0;
    logic [NM*AW-1:0]  addr = '0;
    logic [NM*DW-1:0]  mdout = '0;
    logic [NS*DW-1:0]  sdout = '0;
    logic [NM-1:0]     m_grant;
    logic [DW-1:0]     m_din;
    logic [NS-1:0]     s_sel;
    logic [AW-1:0]     s_address;
    logic              s_wr;
    logic [DW-1:0]     s_din;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    bus_rr_matrix #(.N_MASTER(NM), .N_SLAVE(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .m_req(req), .m_wr(wr), .m_address(addr), .m_dout(mdout),
        .s_dout(sdout), .m_grant(m_grant), .m_din(m_din), .s_sel(s_sel),
        .s_address(s_address), .s_wr(s_wr), .s_din(s_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int own_m = 0;
    int hold_m = 0;
    int selp_m = -1;

    function automatic int slave_of(int o, logic [NM-1:0] r, logic [NM*AW-1:0] a);
        int i;
        i = int'(a[o*AW +: AW]) / (1 << (AW - SW));
        if (r[o] && i < NS) return i;
        return -1;
    endfunction

    // held = consecutive owned cycles under contention counting the current one
    function automatic int next_owner(int o, logic [NM-1:0] r, int held);
        if (r[o] && held < MH) return o;
        for (int k = 1; k < NM; k++)
            if (r[(o + k) % NM]) return (o + k) % NM;
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        int nx, held;
        logic cont;
        if (reset) begin
            own_m  <= 0;
            hold_m <= 0;
            selp_m <= -1;
        end else begin
            cont = (req & ~(NM'(1) << own_m)) != '0;
`ifdef BUS_TIMEOUT_EN
            held = cont ? hold_m + 1 : 0;
`else
            held = 0;
`endif
            nx = next_owner(own_m, req, held);
            selp_m <= slave_of(own_m, req, addr);
            hold_m <= (nx == own_m && cont) ? held : 0;
            own_m  <= nx;
        end
    end

    int c_o, c_s;
    logic [NS-1:0] c_sel;
    always @(negedge clk) begin
        if (chk_en) begin
            c_o = own_m;
            c_s = slave_of(c_o, req, addr);
            c_sel = '0;
            if (c_s >= 0) c_sel[c_s] = 1'b1;
            chk("grant", 64'(m_grant), 64'(NM'(1) << c_o));
            chk("s_address", 64'(s_address), 64'(addr[c_o*AW +: AW]));
            chk("s_din", 64'(s_din), 64'(mdout[c_o*DW +: DW]));
            chk("s_wr", 64'(s_wr), 64'(wr[c_o] & req[c_o]));
            chk("s_sel", 64'(s_sel), 64'(c_sel));
            chk("m_din", 64'(m_din), (selp_m >= 0) ? 64'(sdout[selp_m*DW +: DW]) : 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    logic [NM-1:0] seq [5];

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

        // 1: reset, no requests
        repeat (2) look;
        chk("t1 grant", 64'(m_grant), 64'h1);
        chk("t1 s_sel", 64'(s_sel), 64'h0);
        chk("t1 s_wr", 64'(s_wr), 64'h0);
        chk("t1 m_din", 64'(m_din), 64'h0);
        chk_en = 1'b1;
        reset = 1'b0;

        // 2: master 0 write decoded to slave 1
        req = 4'b0001; wr = 4'b0001;
        addr[0*AW +: AW] = 8'h45; mdout[0*DW +: DW] = 32'hA5A5A5A5;
        #1;
        chk("t2 s_sel", 64'(s_sel), 64'h2);
        chk("t2 s_wr", 64'(s_wr), 64'h1);
        chk("t2 s_din", 64'(s_din), 64'hA5A5A5A5);
        chk("t2 s_address", 64'(s_address), 64'h45);

        // 3: master 1 read from slave 3
        tick;
        req = 4'b0010; wr = 4'b0000;
        addr[1*AW +: AW] = 8'hC0; sdout[3*DW +: DW] = 32'h1234;
        look;
        chk("t3 grant before", 64'(m_grant), 64'h1);
        tick;
        look;
        chk("t3 grant", 64'(m_grant), 64'h2);
        chk("t3 s_sel", 64'(s_sel), 64'h8);
        tick;
        look;
        chk("t3 m_din", 64'(m_din), 64'h1234);

        // 4: everyone requests, owner drops after one cycle -> rotation with wrap
        tick;
        pulse_reset;
        req = 4'b1111 & ~seq[0];
        for (int i = 0; i < 5; i++) begin
            look;
            chk($sformatf("t4 grant[%0d]", i), 64'(m_grant), 64'(seq[i]));
            tick;
            if (i < 4) req = 4'b1111 & ~seq[i+1];
        end

        // 5: master 2 holds while 0 and 3 wait
        pulse_reset;
        req = 4'b0100;
        tick;
        req = 4'b1101;
`ifdef BUS_TIMEOUT_EN
        for (int c = 0; c < 20; c++) begin
            look;
            chk($sformatf("t5 grant c%0d", c), 64'(m_grant), (c < MH) ? 64'h4 : 64'h8);
            tick;
        end
`else
        for (int c = 0; c < 100; c++) begin
            look;
            chk($sformatf("t5 grant c%0d", c), 64'(m_grant), 64'h4);
            tick;
        end
`endif

        // 6: reset in the middle of a master-2 write
        pulse_reset;
        req = 4'b0100; wr = 4'b0100;
        addr[2*AW +: AW] = 8'h85; mdout[2*DW +: DW] = 32'hDEADBEEF;
        tick;
        look;
        chk("t6 grant pre", 64'(m_grant), 64'h4);
        chk("t6 s_wr pre", 64'(s_wr), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 grant", 64'(m_grant), 64'h1);
        chk("t6 m_din", 64'(m_din), 64'h0);
        chk("t6 s_wr", 64'(s_wr), 64'h0);
        chk("t6 s_sel", 64'(s_sel), 64'h0);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0*AW +: AW] = 8'h10;
        #1;
        chk("t6 m0 s_wr", 64'(s_wr), 64'h1);
        chk("t6 m0 s_sel", 64'(s_sel), 64'h1);
        tick;
        reset = 1'b0;

        // randomized traffic, model-checked every cycle
        for (int n = 0; n < 3000; n++) begin
            tick;
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 9) < 3) req[i] = 1'($urandom_range(0, 1));
                wr[i] = 1'($urandom_range(0, 1));
                addr[i*AW +: AW] = AW'($urandom);
                mdout[i*DW +: DW] = $urandom;
            end
            for (int k = 0; k < NS; k++) sdout[k*DW +: DW] = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #1;
                reset = 1'b1;
                look;
                #1;
                reset = 1'b0;
            end
        end

        look;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
